// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch unit's control, redirect, memory and instruction-register signals.
// The master modport is the fetch unit; the slave modport is the surrounding core/memory.
interface instr_fetch_unit_if;
  logic        start;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] ir_data;
  logic        ir_write;
  logic [63:0] pc_out;
  logic        busy;
  logic        fetch_err;

  modport master (
    input  start, redirect_valid, redirect_pc, mem_ack, mem_rdata,
    output mem_req, mem_addr, ir_data, ir_write, pc_out, busy, fetch_err
  );

  modport slave (
    output start, redirect_valid, redirect_pc, mem_ack, mem_rdata,
    input  mem_req, mem_addr, ir_data, ir_write, pc_out, busy, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-instruction fetch FSM (IDLE -> REQ -> WRITE) with branch redirect handling.
// Define FETCH_TIMEOUT_EN to build the mem_ack timeout counter and fetch_err pulse.
module instr_fetch_unit #(
  parameter logic [63:0] PC_RESET    = 64'd0,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master ifu_bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWrite} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ir_q, ir_d;
  logic [63:0] tgt_q, tgt_d;
  logic        pend_q, pend_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // Redirect lands first so a same-cycle start fetches from the new target.
        if (ifu_bus.redirect_valid) begin
          pc_d = {ifu_bus.redirect_pc[63:2], 2'b00};
        end
        if (ifu_bus.start) begin
          state_d = StReq;
        end
`ifdef FETCH_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      StReq: begin
        if (ifu_bus.mem_ack) begin
          if (pend_q || ifu_bus.redirect_valid) begin
            // Stale data: drop it and refetch from the newest target.
            pc_d   = ifu_bus.redirect_valid ? ifu_bus.redirect_pc : tgt_q;
            pend_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_d  = '0;
`endif
          end else begin
            ir_d    = ifu_bus.mem_rdata;
            state_d = StWrite;
          end
        end else begin
          if (ifu_bus.redirect_valid) begin
            pend_d = 1'b1;
            tgt_d  = ifu_bus.redirect_pc;
          end
`ifdef FETCH_TIMEOUT_EN
          if (cnt_q == CntLast) begin
            state_d = StIdle;
            pend_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      StWrite: begin
        pc_d    = ifu_bus.redirect_valid ? ifu_bus.redirect_pc : pc_q + 64'd4;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ifu_bus.fetch_err = err_q;
`else
  assign ifu_bus.fetch_err = 1'b0;
`endif

  assign ifu_bus.mem_req  = (state_q == StReq);
  assign ifu_bus.mem_addr = pc_q;
  assign ifu_bus.ir_data  = ir_q;
  assign ifu_bus.ir_write = (state_q == StWrite);
  assign ifu_bus.pc_out   = pc_q;
  assign ifu_bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a transaction-level PC/IR model.
module tb_instr_fetch_unit;
  localparam logic [63:0] PcReset    = 64'd0;
  localparam int unsigned TimeoutCyc = 16;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .PC_RESET   (PcReset),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ifu_bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural view: the PC and IR a software observer expects.
  logic [63:0] m_pc;
  logic [63:0] m_ir;
  logic [63:0] m_tgt;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  // n REQ cycles without ack (optionally redirecting), then one ack cycle with data.
  task automatic req_cycles(input int unsigned n, input bit redir, input logic [63:0] first_tgt,
                            input logic [63:0] data);
    for (int i = 0; i < int'(n); i++) begin
      check1("req_mem_req", bus.mem_req, 1'b1);
      check("req_mem_addr", bus.mem_addr, m_pc);
      check1("req_no_ir_write", bus.ir_write, 1'b0);
      bus.start = 1'($urandom_range(0, 1));
      if (redir && (i == 0 || $urandom_range(0, 2) == 0)) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = (i == 0) ? first_tgt : rand64();
        m_tgt              = bus.redirect_pc;
      end
      step();
      bus.redirect_valid = 1'b0;
    end
    check1("ack_mem_req", bus.mem_req, 1'b1);
    check("ack_mem_addr", bus.mem_addr, m_pc);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    step();
    bus.mem_ack = 1'b0;
    bus.start   = 1'b0;
  endtask

  task automatic fetch(input bit idle_redir, input logic [63:0] idle_tgt, input int unsigned wait_n,
                       input bit req_redir, input logic [63:0] req_tgt, input logic [63:0] junk,
                       input logic [63:0] rdata, input bit wr_redir, input logic [63:0] wr_tgt);
    bus.start          = 1'b1;
    bus.redirect_valid = idle_redir;
    bus.redirect_pc    = idle_tgt;
    if (idle_redir) m_pc = {idle_tgt[63:2], 2'b00};
    step();
    bus.start          = 1'b0;
    bus.redirect_valid = 1'b0;
    check1("req_busy", bus.busy, 1'b1);
    check("req_pc_out", bus.pc_out, m_pc);
    if (req_redir) begin
      req_cycles((wait_n == 0) ? 1 : wait_n, 1'b1, req_tgt, junk);
      check1("dropped_no_write", bus.ir_write, 1'b0);
      check("dropped_ir_hold", bus.ir_data, m_ir);
      m_pc = m_tgt;
    end
    req_cycles(wait_n, 1'b0, '0, rdata);
    m_ir = rdata;
    check1("wr_ir_write", bus.ir_write, 1'b1);
    check("wr_ir_data", bus.ir_data, m_ir);
    check1("wr_mem_req", bus.mem_req, 1'b0);
    bus.redirect_valid = wr_redir;
    bus.redirect_pc    = wr_tgt;
    bus.mem_ack        = 1'($urandom_range(0, 1));
    bus.start          = 1'($urandom_range(0, 1));
    step();
    idle_inputs();
    m_pc = wr_redir ? wr_tgt : m_pc + 64'd4;
    check1("done_ir_write", bus.ir_write, 1'b0);
    check1("done_busy", bus.busy, 1'b0);
    check("done_pc_out", bus.pc_out, m_pc);
    check("done_ir_hold", bus.ir_data, m_ir);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.start = 1'b1;
    step();
    step();
    reset = 1'b0;
    bus.start = 1'b0;
    m_pc = PcReset;
    m_ir = '0;
    m_tgt = '0;
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_mem_req", bus.mem_req, 1'b0);
    check1("rst_ir_write", bus.ir_write, 1'b0);
    check1("rst_fetch_err", bus.fetch_err, 1'b0);
    check("rst_pc", bus.pc_out, PcReset);
    check("rst_ir", bus.ir_data, 64'd0);

    // Basic fetch at pc=0, ack two cycles after request.
    fetch(1'b0, '0, 1, 1'b0, '0, '0, 64'h00000000_00500093, 1'b0, '0);
    check("basic_pc4", bus.pc_out, 64'd4);
    fetch(1'b0, '0, 0, 1'b0, '0, '0, 64'h1111, 1'b0, '0);
    // Redirect during REQ at pc=8: 0xDEAD dropped, refetch from 0x200.
    fetch(1'b0, '0, 1, 1'b1, 64'h200, 64'hDEAD, 64'h12345678, 1'b0, '0);
    check("req_redir_pc", bus.pc_out, 64'h204);
    // Start plus IDLE redirect to an unaligned target.
    fetch(1'b1, 64'h103, 2, 1'b0, '0, '0, 64'h2222, 1'b0, '0);
    check("idle_redir_pc", bus.pc_out, 64'h104);
    // PC wrap.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFFFFFF_FFFFFFFC;
    step();
    idle_inputs();
    m_pc = 64'hFFFFFFFF_FFFFFFFC;
    check("idle_only_redir", bus.pc_out, m_pc);
    check1("idle_only_busy", bus.busy, 1'b0);
    fetch(1'b0, '0, 1, 1'b0, '0, '0, 64'h3333, 1'b0, '0);
    check("wrap_pc", bus.pc_out, 64'd0);

    for (int t = 0; t < 40; t++) begin
      fetch(($urandom_range(0, 2) == 0), rand64(), $urandom_range(0, 4),
            ($urandom_range(0, 3) == 0), rand64(), rand64(), rand64(),
            ($urandom_range(0, 3) == 0), rand64());
      if ($urandom_range(0, 2) == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rand64();
        step();
        idle_inputs();
        check1("idle_ack_busy", bus.busy, 1'b0);
        check1("idle_ack_no_write", bus.ir_write, 1'b0);
        check("idle_ack_ir", bus.ir_data, m_ir);
      end
    end

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check1("to_mem_req0", bus.mem_req, 1'b1);
`ifdef FETCH_TIMEOUT_EN
    for (int i = 1; i < int'(TimeoutCyc); i++) begin
      step();
      check1("to_mem_req", bus.mem_req, 1'b1);
      check1("to_no_err", bus.fetch_err, 1'b0);
    end
    step();
    check1("to_err", bus.fetch_err, 1'b1);
    check1("to_mem_req_low", bus.mem_req, 1'b0);
    check1("to_busy_low", bus.busy, 1'b0);
    check1("to_no_write", bus.ir_write, 1'b0);
    check("to_pc", bus.pc_out, m_pc);
    step();
    check1("to_err_pulse", bus.fetch_err, 1'b0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
`else
    for (int i = 0; i < 100; i++) step();
    check1("no_to_mem_req", bus.mem_req, 1'b1);
    check1("no_to_err", bus.fetch_err, 1'b0);
`endif

    // Reset while in REQ, then a late ack.
    check1("rq_mem_req", bus.mem_req, 1'b1);
    reset     = 1'b1;
    bus.start = 1'b1;
    step();
    reset     = 1'b0;
    bus.start = 1'b0;
    check1("rq_busy", bus.busy, 1'b0);
    check1("rq_mem_req", bus.mem_req, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hBAD;
    step();
    idle_inputs();
    check1("rq_no_write", bus.ir_write, 1'b0);
    check1("rq_idle", bus.busy, 1'b0);
    check("rq_pc", bus.pc_out, PcReset);
    check("rq_ir", bus.ir_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset SHALL be synchronous and active-high, named reset.
REQ-002 Parameter PC_RESET, default 64'd0: PC value loaded on reset.
REQ-003 Parameter TIMEOUT_CYC, default 16: maximum cycles to wait for mem_ack (used only with FETCH_TIMEOUT_EN).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: start  input  1  control-unit request for one instruction fetch.
REQ-007 Port: redirect_valid  input  1  branch/jump target valid.
REQ-008 Port: redirect_pc  input  64  branch/jump target address.
REQ-009 Port: mem_req  output  1  memory read request, held until acknowledged.
REQ-010 Port: mem_addr  output  64  read address, equals pc while mem_req=1.
REQ-011 Port: mem_ack  input  1  memory read data valid this cycle.
REQ-012 Port: mem_rdata  input  64  memory read data.
REQ-013 Port: ir_data  output  64  fetched word, drives instruction register data input.
REQ-014 Port: ir_write  output  1  one-cycle write strobe to instruction register.
REQ-015 Port: pc_out  output  64  current PC.
REQ-016 Port: busy  output  1  high in any state other than IDLE.
REQ-017 Port: fetch_err  output  1  one-cycle fetch timeout pulse (constant 0 without FETCH_TIMEOUT_EN).

Function
REQ-018 The FSM SHALL have the states IDLE, REQ and WRITE, and SHALL hold state and pc on every clock edge not covered by REQ-019..REQ-027.
REQ-019 IDLE: with start=1, the FSM SHALL go to REQ the next cycle; start SHALL be ignored in REQ and WRITE.
REQ-020 REQ: mem_req=1 and mem_addr=pc; the FSM SHALL stay in REQ until mem_ack=1 is sampled.
REQ-021 REQ with mem_ack=1 and no pending redirect: mem_rdata SHALL be captured into ir_data and the FSM SHALL go to WRITE.
REQ-022 WRITE: ir_write=1 for exactly one cycle; pc SHALL become pc+4 (mod 2^64) and the FSM SHALL return to IDLE.
REQ-023 Latency: with start sampled at edge 0 and mem_ack at edge k (k>=1), ir_write SHALL be high in the cycle after edge k.
REQ-024 redirect_valid in IDLE SHALL load pc<=redirect_pc with bits [1:0] forced to 0; when start is also 1, the fetch SHALL use the redirected pc.
REQ-025 redirect_valid in REQ SHALL set a pending flag and store the target, while mem_req stays high until mem_ack; on mem_ack the data SHALL be discarded (no ir_write), pc SHALL be loaded with the target, the flag SHALL clear, and the FSM SHALL stay in REQ to refetch. A later redirect SHALL overwrite the stored target.
REQ-026 redirect_valid in WRITE: ir_write SHALL still occur, and pc SHALL load redirect_pc instead of pc+4.
REQ-027 mem_ack SHALL be ignored in IDLE and WRITE.
REQ-028 ir_data SHALL hold its value until the next captured fetch.

Reset
REQ-029 When reset=1 at an edge: state<=IDLE, pc<=PC_RESET, ir_data<=0, pending flag and timeout counter cleared; mem_req, ir_write, busy and fetch_err SHALL be 0 the next cycle. Reset SHALL override all other inputs.
REQ-030 Reset during REQ SHALL abandon the request; a late mem_ack SHALL be ignored.

Configuration
REQ-031 With macro FETCH_TIMEOUT_EN defined:
  - a counter SHALL clear on entering REQ and increment each REQ cycle without mem_ack;
  - reaching TIMEOUT_CYC SHALL drop mem_req, pulse fetch_err for 1 cycle, and return to IDLE with pc unchanged and no ir_write.
REQ-032 Without FETCH_TIMEOUT_EN: no counter is built, fetch_err SHALL be tied to 0, and REQ SHALL wait indefinitely.

Verification
REQ-033 Reset, then start=1 at pc=0, mem_ack 2 cycles after mem_req with rdata=64'h00000000_00500093 -> mem_addr=0, ir_write one cycle, ir_data=64'h00500093, pc_out=4.
REQ-034 IDLE, start=1 and redirect_valid=1 with redirect_pc=64'h103 in the same cycle -> mem_addr=64'h100; after ack, pc_out=64'h104.
REQ-035 redirect_pc=64'h200 during REQ at pc=8, ack rdata=64'hDEAD -> no ir_write for 64'hDEAD, next mem_addr=64'h200, second ack writes IR, pc_out=64'h204.
REQ-036 pc=64'hFFFFFFFF_FFFFFFFC fetch completes -> pc_out wraps to 0.
REQ-037 FETCH_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ack never asserted -> fetch_err pulse after 16 REQ cycles, mem_req low, busy low, pc unchanged; without macro, mem_req still high after 100 cycles.
REQ-038 reset asserted in REQ, then mem_ack the next cycle -> no ir_write, pc_out=PC_RESET, state IDLE.
